// File: rtl/artemis_ddr3_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : artemis_ddr3_port_ctrl_if
// Description : Host request/data signals and MCB user-port signals for one
//               Artemis DDR3 port controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface artemis_ddr3_port_ctrl_if;
    // Host side
    logic        calibration_done;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [29:0] req_addr;
    logic [5:0]  req_len;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic [3:0]  wdat_mask;
    logic        rdat_valid;
    logic        rdat_ready;
    logic [31:0] rdat;
    logic        busy;
    logic        done;
    logic        error;
    // MCB user port side
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wr_underrun;
    logic        wr_error;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic        rd_overflow;
    logic        rd_error;

    // Controller view
    modport slave (
        input  calibration_done, req_valid, req_write, req_addr, req_len,
               wdat_valid, wdat, wdat_mask, rdat_ready,
               cmd_full, wr_full, wr_underrun, wr_error,
               rd_data, rd_empty, rd_overflow, rd_error,
        output req_ready, wdat_ready, rdat_valid, rdat, busy, done, error,
               cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
               wr_en, wr_mask, wr_data, rd_en
    );

    // Host + MCB environment view
    modport master (
        output calibration_done, req_valid, req_write, req_addr, req_len,
               wdat_valid, wdat, wdat_mask, rdat_ready,
               cmd_full, wr_full, wr_underrun, wr_error,
               rd_data, rd_empty, rd_overflow, rd_error,
        input  req_ready, wdat_ready, rdat_valid, rdat, busy, done, error,
               cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
               wr_en, wr_mask, wr_data, rd_en
    );
endinterface
`default_nettype wire

// File: rtl/artemis_ddr3_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : artemis_ddr3_port_ctrl
// Description : Single MCB user-port transaction controller. Moves one host
//               burst through the write-data, command and read-data FIFOs,
//               handles FIFO backpressure and reports done / sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module artemis_ddr3_port_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    artemis_ddr3_port_ctrl_if.slave bus
);

    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [2:0]        c_INSTR_WR = 3'b000;
    localparam logic [2:0]        c_INSTR_RD = 3'b001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_FILL  = 3'd1,
        WR_CMD   = 3'd2,
        RD_CMD   = 3'd3,
        RD_DRAIN = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [29:0]          r_addr;
    logic [5:0]           r_len;
    logic [2:0]           r_instr;
    logic [5:0]           r_cnt;
    logic [c_TMO_W-1:0]   r_tmo;
    logic                 r_cmd_en;
    logic                 r_done;
    logic                 r_error;

    logic                 w_req_ready;
    logic                 w_wdat_ready;
    logic                 w_wr_en;
    logic                 w_rdat_valid;
    logic                 w_rd_en;
    logic                 w_cmd_go;
    logic                 w_done_set;
    logic                 w_tmo_hit;
    logic                 w_accept;
    logic                 w_mcb_err;

    assign w_accept  = w_req_ready & bus.req_valid;
    assign w_mcb_err = bus.wr_underrun | bus.wr_error | bus.rd_overflow | bus.rd_error;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and combinational handshakes for the current state
    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_wdat_ready = 1'b0;
        w_wr_en      = 1'b0;
        w_rdat_valid = 1'b0;
        w_rd_en      = 1'b0;
        w_cmd_go     = 1'b0;
        w_done_set   = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted then
                w_req_ready = bus.calibration_done & ~rst;
                if (bus.req_valid && w_req_ready) begin
                    w_next = bus.req_write ? WR_FILL : RD_CMD;
                end
            end
            WR_FILL: begin
                w_wdat_ready = ~bus.wr_full;
                w_wr_en      = bus.wdat_valid & ~bus.wr_full;
                if (w_wr_en && (r_cnt == r_len)) begin
                    w_next = WR_CMD;
                end
            end
            WR_CMD: begin
                if (!bus.cmd_full) begin
                    w_cmd_go   = 1'b1;
                    w_done_set = 1'b1;
                    w_next     = IDLE;
                end
            end
            RD_CMD: begin
                if (!bus.cmd_full) begin
                    w_cmd_go = 1'b1;
                    w_next   = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                w_rdat_valid = ~bus.rd_empty;
                w_rd_en      = ~bus.rd_empty & bus.rdat_ready;
                if (w_rd_en && (r_cnt == r_len)) begin
                    w_done_set = 1'b1;
                    w_next     = IDLE;
                end else if (bus.rd_empty && (r_tmo == c_TMO_LAST)) begin
                    // Late data is left in the MCB FIFO; recovery needs a reset
                    w_tmo_hit = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request latch, beat counter, drain timeout, command/done pulses and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_instr  <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_cmd_en <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_cmd_en <= w_cmd_go;
            r_done   <= w_done_set;

            if (w_accept) begin
                r_addr  <= bus.req_addr & 30'h3FFF_FFFC;
                r_len   <= bus.req_len;
                r_instr <= bus.req_write ? c_INSTR_WR : c_INSTR_RD;
                r_cnt   <= '0;
            end else if (w_wr_en || w_rd_en) begin
                r_cnt <= r_cnt + 6'd1;
            end

            if (w_accept || (r_state != RD_DRAIN) || !bus.rd_empty) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end

            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_tmo_hit || ((r_state != IDLE) && w_mcb_err)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.wdat_ready    = w_wdat_ready;
    assign bus.wr_en         = w_wr_en;
    assign bus.wr_data       = bus.wdat;
    assign bus.wr_mask       = bus.wdat_mask;
    assign bus.rdat_valid    = w_rdat_valid;
    assign bus.rdat          = bus.rd_data;
    assign bus.rd_en         = w_rd_en;
    assign bus.busy          = (r_state != IDLE);
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.cmd_en        = r_cmd_en;
    assign bus.cmd_instr     = r_instr;
    assign bus.cmd_bl        = r_len;
    assign bus.cmd_byte_addr = r_addr;

endmodule
`default_nettype wire
